// File: rtl/vtage_update_ctrl_if.sv
// Commit-outcome, bank-probe and bank-update lanes of one VTAGE update controller.
// The controller takes the slave view; the commit side and the bank take the master view.
interface vtage_update_ctrl_if #(
   parameter int unsigned P_NUM_ENTRIES = 256,
   parameter int unsigned P_TAG_WIDTH   = 8,
   parameter int unsigned P_VALUE_WIDTH = 32,
   parameter int unsigned P_FAIL_WIDTH  = 4
);
   localparam int unsigned LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES);

   logic                      cm_valid_i;
   logic                      cm_ready_o;
   logic [LP_INDEX_WIDTH-1:0] cm_index_i;
   logic [P_TAG_WIDTH-1:0]    cm_tag_i;
   logic                      cm_hit_i;
   logic [P_VALUE_WIDTH-1:0]  cm_pred_value_i;
   logic [P_VALUE_WIDTH-1:0]  cm_act_value_i;

   logic [LP_INDEX_WIDTH-1:0] fb_index_o;
   logic [P_TAG_WIDTH-1:0]    fb_tag_o;
   logic                      fb_alloc_avail_i;

   logic                      ud_valid_o;
   logic [LP_INDEX_WIDTH-1:0] ud_index_o;
   logic                      ud_incr_conf_o;
   logic                      ud_rst_conf_o;
   logic                      ud_incr_use_o;
   logic                      ud_decr_use_o;
   logic                      ud_rst_use_o;
   logic                      ud_load_tag_o;
   logic                      ud_load_value_o;
   logic [P_TAG_WIDTH-1:0]    ud_tag_o;
   logic [P_VALUE_WIDTH-1:0]  ud_value_o;

   logic [P_FAIL_WIDTH-1:0]   alloc_fail_cnt_o;
   logic                      age_o;

   modport slave (
      input  cm_valid_i, cm_index_i, cm_tag_i, cm_hit_i, cm_pred_value_i, cm_act_value_i,
      input  fb_alloc_avail_i,
      output cm_ready_o, fb_index_o, fb_tag_o,
      output ud_valid_o, ud_index_o, ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o,
      output ud_decr_use_o, ud_rst_use_o, ud_load_tag_o, ud_load_value_o, ud_tag_o, ud_value_o,
      output alloc_fail_cnt_o, age_o
   );

   modport master (
      output cm_valid_i, cm_index_i, cm_tag_i, cm_hit_i, cm_pred_value_i, cm_act_value_i,
      output fb_alloc_avail_i,
      input  cm_ready_o, fb_index_o, fb_tag_o,
      input  ud_valid_o, ud_index_o, ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o,
      input  ud_decr_use_o, ud_rst_use_o, ud_load_tag_o, ud_load_value_o, ud_tag_o, ud_value_o,
      input  alloc_fail_cnt_o, age_o
   );
endinterface

// File: rtl/vtage_update_ctrl.sv
// VTAGE bank update controller: queues committed outcomes and turns each into exactly one
// bank update (confidence/useful update on hit, probe then allocate-or-decay on miss).
module vtage_update_ctrl #(
   parameter int unsigned P_NUM_ENTRIES = 256,
   parameter int unsigned P_TAG_WIDTH   = 8,
   parameter int unsigned P_VALUE_WIDTH = 32,
   parameter int unsigned P_FIFO_DEPTH  = 4,
   parameter int unsigned P_FAIL_WIDTH  = 4
) (
   input logic                clk_i,
   input logic                rst_i,
   vtage_update_ctrl_if.slave bus
);
   localparam int unsigned LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES);
   localparam int unsigned LP_PTR_WIDTH   = $clog2(P_FIFO_DEPTH);

   localparam logic [LP_PTR_WIDTH:0]   LP_PTR_ONE   = {{LP_PTR_WIDTH{1'b0}}, 1'b1};
   localparam logic [P_FAIL_WIDTH-1:0] LP_FAIL_ONE  = {{(P_FAIL_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_FAIL_WIDTH-1:0] LP_FAIL_LAST = {{(P_FAIL_WIDTH-1){1'b1}}, 1'b0};

   typedef struct packed {
      logic [LP_INDEX_WIDTH-1:0] index;
      logic [P_TAG_WIDTH-1:0]    tag;
      logic                      hit;
      logic                      correct;
      logic [P_VALUE_WIDTH-1:0]  act_value;
   } entry_t;

   typedef enum logic [2:0] {
      StIdle,
      StUpd,
      StProbe,
      StAlloc,
      StDecay
   } state_e;

   state_e                  state_q, state_d;
   entry_t                  head_q, head_d;
   logic [P_FAIL_WIDTH-1:0] fail_q, fail_d;

   entry_t                  mem_q [P_FIFO_DEPTH];
   entry_t                  push_entry;
   logic [LP_PTR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
   logic                    empty, full, push, pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[LP_PTR_WIDTH] != rd_ptr_q[LP_PTR_WIDTH]) &&
                  (wr_ptr_q[LP_PTR_WIDTH-1:0] == rd_ptr_q[LP_PTR_WIDTH-1:0]);
   assign push  = bus.cm_valid_i && !full;
   assign pop   = (state_q == StIdle) && !empty;

   assign bus.cm_ready_o = !full;

   always_comb begin
      push_entry.index     = bus.cm_index_i;
      push_entry.tag       = bus.cm_tag_i;
      push_entry.hit       = bus.cm_hit_i;
      push_entry.correct   = (bus.cm_pred_value_i == bus.cm_act_value_i);
      push_entry.act_value = bus.cm_act_value_i;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[LP_PTR_WIDTH-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= StIdle;
         head_q   <= '0;
         fail_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + LP_PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + LP_PTR_ONE;
         state_q <= state_d;
         head_q  <= head_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      fail_d  = fail_q;

      bus.fb_index_o      = '0;
      bus.fb_tag_o        = '0;
      bus.ud_valid_o      = 1'b0;
      bus.ud_index_o      = '0;
      bus.ud_incr_conf_o  = 1'b0;
      bus.ud_rst_conf_o   = 1'b0;
      bus.ud_incr_use_o   = 1'b0;
      bus.ud_decr_use_o   = 1'b0;
      bus.ud_rst_use_o    = 1'b0;
      bus.ud_load_tag_o   = 1'b0;
      bus.ud_load_value_o = 1'b0;
      bus.ud_tag_o        = '0;
      bus.ud_value_o      = '0;
      bus.age_o           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               head_d  = mem_q[rd_ptr_q[LP_PTR_WIDTH-1:0]];
               state_d = mem_q[rd_ptr_q[LP_PTR_WIDTH-1:0]].hit ? StUpd : StProbe;
            end
         end
         StUpd: begin
            bus.ud_valid_o = 1'b1;
            bus.ud_index_o = head_q.index;
            if (head_q.correct) begin
               bus.ud_incr_conf_o = 1'b1;
               bus.ud_incr_use_o  = 1'b1;
            end else begin
               bus.ud_rst_conf_o   = 1'b1;
               bus.ud_decr_use_o   = 1'b1;
               bus.ud_load_value_o = 1'b1;
               bus.ud_value_o      = head_q.act_value;
            end
            state_d = StIdle;
         end
         StProbe: begin
            bus.fb_index_o = head_q.index;
            bus.fb_tag_o   = head_q.tag;
            state_d        = bus.fb_alloc_avail_i ? StAlloc : StDecay;
         end
         StAlloc: begin
            bus.ud_valid_o      = 1'b1;
            bus.ud_index_o      = head_q.index;
            bus.ud_load_tag_o   = 1'b1;
            bus.ud_tag_o        = head_q.tag;
            bus.ud_load_value_o = 1'b1;
            bus.ud_value_o      = head_q.act_value;
            bus.ud_rst_conf_o   = 1'b1;
            bus.ud_rst_use_o    = 1'b1;
            fail_d              = '0;
            state_d             = StIdle;
         end
         StDecay: begin
            bus.ud_valid_o    = 1'b1;
            bus.ud_index_o    = head_q.index;
            bus.ud_decr_use_o = 1'b1;
            // Reaching all-ones triggers a global aging request instead of saturating.
            if (fail_q == LP_FAIL_LAST) begin
               bus.age_o = 1'b1;
               fail_d    = '0;
            end else begin
               fail_d = fail_q + LP_FAIL_ONE;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.alloc_fail_cnt_o = fail_q;
endmodule
